// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, indices and WB pipeline register type
package wb_pkg;

  localparam int DATA_W    = 64;
  localparam int ZERO_REG  = 31;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef struct packed {
    logic                 valid;
    logic                 regwrite;
    logic [REG_IDX_W-1:0] rd;
    logic [DATA_W-1:0]    data;
  } wb_reg_t;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM-stage input, pipeline control, read ports and WB forwarding outputs
interface wb_regfile_if;
  import wb_pkg::*;

  logic                 mem_valid;
  logic                 mem_regwrite;
  logic [REG_IDX_W-1:0] mem_rd;
  logic [DATA_W-1:0]    mem_data;
  logic                 stall;
  logic                 flush;
  logic [REG_IDX_W-1:0] rn_addr;
  logic [REG_IDX_W-1:0] rm_addr;
  logic [DATA_W-1:0]    rn_data;
  logic [DATA_W-1:0]    rm_data;
  logic                 wb_we;
  logic [REG_IDX_W-1:0] wb_rd;
  logic [DATA_W-1:0]    wb_data;

  modport master (
    output mem_valid, mem_regwrite, mem_rd, mem_data, stall, flush, rn_addr, rm_addr,
    input  rn_data, rm_data, wb_we, wb_rd, wb_data
  );

  modport slave (
    input  mem_valid, mem_regwrite, mem_rd, mem_data, stall, flush, rn_addr, rm_addr,
    output rn_data, rm_data, wb_we, wb_rd, wb_data
  );

endinterface

// File: rtl/decoder5x32.sv
// rtl/decoder5x32.sv - one-hot register write-enable decoder
module decoder5x32
  import wb_pkg::*;
(
  input  logic                 enable,
  input  logic [REG_IDX_W-1:0] in,
  output logic [NUM_REGS-1:0]  out
);

  always_comb begin
    out = '0;
    if (enable) out[in] = 1'b1;
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - WB pipeline register plus 2-read/1-write register file with XZR and bypass
module wb_regfile #(
  parameter int DATA_W   = wb_pkg::DATA_W,
  parameter int ZERO_REG = wb_pkg::ZERO_REG
) (
  input  logic          clk,
  input  logic          reset,
  wb_regfile_if.slave   bus
);
  import wb_pkg::wb_reg_t;
  import wb_pkg::REG_IDX_W;
  import wb_pkg::NUM_REGS;

  localparam logic [REG_IDX_W-1:0] ZERO_IDX = REG_IDX_W'(ZERO_REG);

  wb_reg_t              wb_q, wb_d;
  logic                 wb_we;
  logic [NUM_REGS-1:0]  we_onehot;
  logic [DATA_W-1:0]    regs_rd [NUM_REGS];
  logic [DATA_W-1:0]    rn_val, rm_val;
  logic                 unused_zero_we;

  // Flush only clears valid; the other fields keep their last value.
  always_comb begin
    wb_d = wb_q;
    if (bus.flush) begin
      wb_d.valid = 1'b0;
    end else if (!bus.stall) begin
      wb_d.valid    = bus.mem_valid;
      wb_d.regwrite = bus.mem_regwrite;
      wb_d.rd       = bus.mem_rd;
      wb_d.data     = bus.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  assign wb_we = wb_q.valid & wb_q.regwrite & (wb_q.rd != ZERO_IDX);

  decoder5x32 u_dec (
    .enable (wb_we),
    .in     (wb_q.rd),
    .out    (we_onehot)
  );

  assign unused_zero_we = we_onehot[ZERO_REG];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    if (g == ZERO_REG) begin : g_zero
      assign regs_rd[g] = '0;
    end else begin : g_flop
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk) begin
        if (reset)             q <= '0;
        else if (we_onehot[g]) q <= wb_q.data;
      end
      assign regs_rd[g] = q;
    end
  end

  // Later assignments win: XZR beats bypass beats array.
  always_comb begin
    rn_val = regs_rd[bus.rn_addr];
    if (wb_we && bus.rn_addr == wb_q.rd) rn_val = wb_q.data;
    if (bus.rn_addr == ZERO_IDX)         rn_val = '0;
  end

  always_comb begin
    rm_val = regs_rd[bus.rm_addr];
    if (wb_we && bus.rm_addr == wb_q.rd) rm_val = wb_q.data;
    if (bus.rm_addr == ZERO_IDX)         rm_val = '0;
  end

  assign bus.rn_data = rn_val;
  assign bus.rm_data = rm_val;
  assign bus.wb_we   = wb_we;
  assign bus.wb_rd   = wb_q.rd;
  assign bus.wb_data = wb_q.data;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile with directed and random traffic
module tb_wb_regfile;
  import wb_pkg::*;

  typedef struct {
    logic [DATA_W-1:0] rn;
    logic [DATA_W-1:0] rm;
    logic              we;
    logic [4:0]        rd;
    logic [DATA_W-1:0] wd;
    string             tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_regfile_if bus();

  wb_regfile #(.DATA_W(DATA_W), .ZERO_REG(ZERO_REG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t expq[$];
  exp_t me;

  // Architectural state and the write sitting in the WB stage.
  logic [DATA_W-1:0] arch [32];
  bit                p_valid, p_rw;
  logic [4:0]        p_rd;
  logic [DATA_W-1:0] p_data;
  bit                known = 0;

  function automatic bit pend_commits();
    return p_valid && p_rw && (p_rd != 5'(ZERO_REG));
  endfunction

  function automatic logic [DATA_W-1:0] mread(input logic [4:0] a);
    if (a == 5'(ZERO_REG)) return '0;
    if (pend_commits() && p_rd == a) return p_data;
    return arch[a];
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      me = expq.pop_front();
      chk({me.tag, ".rn_data"}, bus.rn_data, me.rn);
      chk({me.tag, ".rm_data"}, bus.rm_data, me.rm);
      chk({me.tag, ".wb_we"},   DATA_W'(bus.wb_we), DATA_W'(me.we));
      chk({me.tag, ".wb_rd"},   DATA_W'(bus.wb_rd), DATA_W'(me.rd));
      chk({me.tag, ".wb_data"}, bus.wb_data, me.wd);
    end
  end

  task automatic cyc(input bit rst, input bit mv, input bit mrw, input logic [4:0] mrd,
                     input logic [DATA_W-1:0] md, input bit st, input bit fl,
                     input logic [4:0] ra, input logic [4:0] rb, input string tag);
    exp_t e;
    reset            = rst;
    bus.mem_valid    = mv;
    bus.mem_regwrite = mrw;
    bus.mem_rd       = mrd;
    bus.mem_data     = md;
    bus.stall        = st;
    bus.flush        = fl;
    bus.rn_addr      = ra;
    bus.rm_addr      = rb;
    if (known) begin
      e.rn  = mread(ra);
      e.rm  = mread(rb);
      e.we  = pend_commits();
      e.rd  = p_rd;
      e.wd  = p_data;
      e.tag = tag;
      expq.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) arch[i] = '0;
      p_valid = 0; p_rw = 0; p_rd = '0; p_data = '0;
      known = 1;
    end else begin
      if (pend_commits()) arch[p_rd] = p_data;
      if (fl) p_valid = 0;
      else if (!st) begin
        p_valid = mv; p_rw = mrw; p_rd = mrd; p_data = md;
      end
    end
    #1;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [DATA_W-1:0] d,
                    input logic [4:0] ra, input logic [4:0] rb, input string tag);
    cyc(0, 1, 1, rd, d, 0, 0, ra, rb, tag);
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb, input string tag);
    cyc(0, 0, 0, 5'd0, '0, 0, 0, ra, rb, tag);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) idle(5'(a), 5'(a + 16), tag);
  endtask

  function automatic logic [4:0] pick_idx();
    if ($urandom_range(0, 5) == 0) return 5'(ZERO_REG);
    return 5'($urandom_range(0, 7));
  endfunction

  initial begin
    cyc(1, 0, 0, 5'd0, '0, 0, 0, 5'd0, 5'd0, "reset0");
    cyc(1, 1, 1, 5'd4, 64'h77, 0, 0, 5'd4, 5'd31, "reset1");
    sweep("after_reset");

    ld(5'd3, 64'hDEAD, 5'd3, 5'd0, "dead_load");
    idle(5'd3, 5'd3, "dead_bypass");
    idle(5'd3, 5'd3, "dead_array");

    ld(5'd31, 64'h1234, 5'd31, 5'd31, "xzr_load");
    idle(5'd31, 5'd31, "xzr_wb");
    idle(5'd31, 5'd31, "xzr_after");

    cyc(0, 1, 1, 5'd5, 64'hAA, 1, 1, 5'd5, 5'd5, "flush_stall");
    idle(5'd5, 5'd5, "flush_wb");
    idle(5'd5, 5'd5, "flush_after");

    ld(5'd7, 64'h55, 5'd7, 5'd6, "stall_load");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 5'(8 + i), 64'(32'hF00 + i), 1, 0, 5'd7, 5'(8 + i), "stall_hold");
    idle(5'd7, 5'd8, "stall_release");
    sweep("stall_sweep");

    ld(5'd9, 64'h11, 5'd9, 5'd0, "rst9_a");
    ld(5'd9, 64'h22, 5'd9, 5'd1, "rst9_b");
    cyc(1, 0, 0, 5'd0, '0, 0, 0, 5'd0, 5'd1, "rst9_reset");
    idle(5'd9, 5'd9, "rst9_after");
    idle(5'd9, 5'd9, "rst9_after2");

    ld(5'd2, 64'h1, 5'd2, 5'd2, "b2b_1");
    ld(5'd2, 64'h2, 5'd2, 5'd2, "b2b_2");
    idle(5'd2, 5'd2, "b2b_3");
    idle(5'd2, 5'd2, "b2b_4");

    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
          pick_idx(), {$urandom, $urandom},
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
          pick_idx(), pick_idx(), "rand");
    end
    sweep("final_sweep");

    for (int w = 0; w < 5 && expq.size() > 0; w++) @(negedge clk);
    chk("queue_drain", DATA_W'(expq.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, 64, register and data width in bits.
REQ-002 Parameter ZERO_REG, 31, index of the hardwired-zero register (XZR).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 mem_valid  in  1  MEM-stage result valid this cycle.
REQ-006 mem_regwrite  in  1  MEM-stage instruction writes a register.
REQ-007 mem_rd  in  5  MEM-stage destination register index.
REQ-008 mem_data  in  DATA_W  MEM-stage result value.
REQ-009 stall  in  1  hold the WB pipeline register.
REQ-010 flush  in  1  invalidate the WB pipeline register.
REQ-011 rn_addr, rm_addr  in  5 each  read-port register indices.
REQ-012 rn_data, rm_data  out  DATA_W each  read-port data, combinational.
REQ-013 wb_we  out  1  WB register holds a committing write (for the forwarding unit).
REQ-014 wb_rd  out  5  WB register destination index.
REQ-015 wb_data  out  DATA_W  WB register value.

Function
REQ-016 WB pipeline register fields: valid, regwrite, rd, data.
- Edge-update priority: reset > flush > stall > load.
REQ-017 Load:
- At edge N, with no stall, flush or reset, the register captures mem_valid, mem_regwrite, mem_rd and mem_data.
REQ-018 Stall:
- The register holds all fields.
- A held committing write is re-written every held cycle; it is idempotent by design.
REQ-019 Flush: valid=0 at the next edge, regardless of stall.
REQ-020 wb_we = valid & regwrite & (rd != ZERO_REG); purely combinational from the WB register.
REQ-021 Commit:
- If wb_we=1 at edge N+1, the 64-bit register array entry wb_rd takes wb_data.
- Capture-to-architectural-update latency is 2 edges.
REQ-022 Write-enable decode:
- Per-register one-hot enables from a 5:32 decode of wb_rd, gated by wb_we.
- At most one entry is written per cycle.
REQ-023 Entry ZERO_REG has no storage: it always reads 0 and ignores writes.
REQ-024 Read resolution per port, in priority order:
- addr==ZERO_REG gives 0.
- addr==wb_rd with wb_we=1 gives wb_data (bypass).
- Otherwise the array entry.
REQ-025 Both ports may read the same index; each resolves independently and identically.
REQ-026 wb_rd and wb_data are driven even when valid=0; consumers qualify with wb_we.

Reset
REQ-027 When reset=1 at an edge:
- WB register becomes valid=0, regwrite=0, rd=0, data=0.
- All 31 array entries clear to 0.
REQ-028 A write pending in the WB register at a reset edge is discarded, not committed.
REQ-029 Output values after reset: wb_we=0, wb_rd=0, wb_data=0, and rn_data/rm_data=0 for any address.
REQ-030 While reset is held: state stays cleared; loads and writes are suppressed.

Structure
REQ-031 Shared package wb_pkg holds DATA_W, ZERO_REG, REG_IDX_W=5, NUM_REGS=32, and the WB-register struct type.
REQ-032 One sub-module: decoder5x32, the 5:32 enable decoder (enable, in[4:0], out[31:0]).
REQ-033 The array and the WB register are flat flops in wb_regfile; the array has no reset-less storage.

Verification
REQ-034 Reset, then load rd=3, data=0xDEAD, valid=1, regwrite=1:
- wb_we=1 after edge 1.
- rn_addr=3 returns 0xDEAD via bypass.
- After edge 2 with mem_valid=0, rn_addr=3 still returns 0xDEAD from the array.
REQ-035 Load rd=31, data=0x1234, valid=1, regwrite=1:
- wb_we=0.
- rn_addr=31 and rm_addr=31 read 0 in every cycle.
REQ-036 Load rd=5, data=0xAA, then assert flush and stall together at the next edge:
- valid=0 and wb_we=0.
- rn_addr=5 reads the previous value 0.
REQ-037 Stall for 3 edges with WB holding rd=7, data=0x55 while mem_* change:
- wb_rd=7 and wb_data=0x55 held throughout.
- Entry 7 = 0x55.
- No other entry is modified.
REQ-038 Write rd=9=0x11, then assert reset at the edge where rd=9=0x22 sits in WB:
- Entry 9=0 and wb_we=0.
- 0x22 is never observable on rn_data.
REQ-039 Back-to-back writes rd=2=0x1, then rd=2=0x2, with rn_addr=rm_addr=2:
- Ports read 0x1, then 0x2, then 0x2 on successive cycles.
- Both ports are identical in every cycle.
